// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory responder.
//                The package holds the FSM state codes, the access size codes
//                (these equal funct3[1:0]) and the MMIO register offsets.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Access size codes; the value 2'd3 is illegal
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // MMIO register offsets from IO_BASE
    localparam logic [31:0] IO_OUT_OFF = 32'd0;
    localparam logic [31:0] IO_CYC_OFF = 32'd4;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane steering for the responder.
//                Store side: byte enables plus write data replicated into lanes.
//                Load side : byte or half selected from the read word, then
//                            sign- or zero-extended.
//                It also flags a misaligned access. An illegal size is flagged
//                by the caller.
//  Ports       : i_size      access size code (SZ_B/SZ_H/SZ_W)
//                i_unsigned  zero-extend sub-word loads when 1
//                i_addr_lo   byte offset inside the word
//                i_wdata     store data, value in the low bits
//                i_rword     word read from RAM/MMIO in the access cycle
//                o_byte_en   lanes written by a store
//                o_wword     store data steered into the lanes
//                o_rdata_ext extended load result
//                o_misaligned half on an odd address, or word not on a 4-byte boundary
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata_ext,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte       = 8'h00;
        w_half       = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_byte_en    = 4'b0000;
        o_wword      = 32'h0;
        o_rdata_ext  = 32'h0;
        o_misaligned = 1'b0;

        case (i_addr_lo)
            2'd0:    w_byte = i_rword[7:0];
            2'd1:    w_byte = i_rword[15:8];
            2'd2:    w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase

        case (i_size)
            SZ_B: begin
                o_byte_en   = 4'b0001 << i_addr_lo;
                o_wword     = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SZ_H: begin
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword      = {2{i_wdata[15:0]}};
                o_rdata_ext  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            SZ_W: begin
                // Word loads ignore the unsigned flag.
                o_byte_en    = 4'b1111;
                o_wword      = i_wdata;
                o_rdata_ext  = i_rword;
                o_misaligned = (i_addr_lo != 2'd0);
            end
            default: begin
                o_byte_en = 4'b0000;
            end
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Responder end of the core's data-memory interface.
//                It accepts one load or store at a time and serves it from
//                word-organised RAM or from two MMIO registers. The MMIO
//                registers are io_out (RW) and a free-running cycle counter
//                (RO). WAIT_CYCLES extra cycles model slow memory.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_ready       request handshake (ready in IDLE only)
//                req_we/size/unsigned/addr/wdata  request fields, latched on accept
//                rsp_valid                 one-cycle response strobe
//                rsp_rdata/rsp_err         response, held until the next response
//                io_out                    MMIO output register
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] io_out
);

    localparam int          c_AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int          c_WLOAD   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam int          c_CW      = (c_WLOAD > 1) ? $clog2(c_WLOAD + 1) : 1;
    localparam bit          c_NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [29:0] c_DEPTH_W = 30'(DEPTH);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [c_CW-1:0] r_cnt;
    logic            r_ready;
    logic            r_we;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_rsp_rdata;
    logic            r_rsp_err;
    logic [31:0]     r_io_out;
    logic [31:0]     r_cyc_cnt;
    logic [31:0]     r_mem [DEPTH];

    // In IDLE the live request is examined, because the error check and,
    // with no wait states, the access itself both happen on the accept edge.
    // After that only the latched copy is used.
    logic            w_idle;
    logic            w_cur_we;
    logic [1:0]      w_cur_size;
    logic            w_cur_uns;
    logic [31:0]     w_cur_addr;
    logic [31:0]     w_cur_wdata;
    logic            w_in_ram;
    logic            w_io_out;
    logic            w_io_cyc;
    logic            w_io_any;
    logic            w_misaligned;
    logic            w_err;
    logic            w_accept;
    logic            w_do_access;
    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rword;
    logic [3:0]      w_be;
    logic [31:0]     w_wword;
    logic [31:0]     w_rdata_ext;

    assign w_idle      = (r_state == S_IDLE);
    assign w_cur_we    = w_idle ? req_we       : r_we;
    assign w_cur_size  = w_idle ? req_size     : r_size;
    assign w_cur_uns   = w_idle ? req_unsigned : r_uns;
    assign w_cur_addr  = w_idle ? req_addr     : r_addr;
    assign w_cur_wdata = w_idle ? req_wdata    : r_wdata;

    assign w_in_ram = (w_cur_addr[31:2] < c_DEPTH_W);
    assign w_io_out = (w_cur_addr == IO_BASE + IO_OUT_OFF);
    assign w_io_cyc = (w_cur_addr == IO_BASE + IO_CYC_OFF);
    assign w_io_any = w_io_out | w_io_cyc;
    assign w_idx    = w_cur_addr[c_AW+1:2];

    assign w_err = (w_cur_size == 2'd3)
                 | w_misaligned
                 | ~(w_in_ram | w_io_any)
                 | (w_io_any & (w_cur_size != SZ_W))
                 | (w_io_cyc & w_cur_we);

    // r_ready is registered, so it is already 0 while reset is asserted.
    // It can only be 1 in IDLE.
    assign w_accept    = req_valid & r_ready;
    assign w_do_access = (w_accept & ~w_err & c_NO_WAIT)
                       | ((r_state == S_WAIT) && (r_cnt == '0));

    assign w_rword = w_io_out ? r_io_out :
                     w_io_cyc ? r_cyc_cnt : r_mem[w_idx];

    lsu_align u_align (
        .i_size       (w_cur_size),
        .i_unsigned   (w_cur_uns),
        .i_addr_lo    (w_cur_addr[1:0]),
        .i_wdata      (w_cur_wdata),
        .i_rword      (w_rword),
        .o_byte_en    (w_be),
        .o_wword      (w_wword),
        .o_rdata_ext  (w_rdata_ext),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = (w_err || c_NO_WAIT) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nx = S_RESP;
                end
            end
            S_RESP:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_io_out    <= 32'h0;
            r_cyc_cnt   <= 32'h0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
            r_ready   <= (w_state_nx == S_IDLE);

            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_CW'(c_WLOAD);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CW'(1);
            end

            if (w_accept && w_err) begin
                r_rsp_err   <= 1'b1;
                r_rsp_rdata <= 32'h0;
            end else if (w_do_access) begin
                r_rsp_err   <= 1'b0;
                r_rsp_rdata <= w_cur_we ? 32'h0 : w_rdata_ext;
                if (w_cur_we && w_io_out) begin
                    r_io_out <= w_cur_wdata;
                end
            end
        end
    end

    // RAM contents are deliberately not reset; only the enabled lanes change.
    always_ff @(posedge clk) begin
        if (w_do_access && w_cur_we && w_in_ram && !w_io_any) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign io_out    = r_io_out;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Each request pushes
//                its expected response into a scoreboard queue. The entry is
//                popped and compared when rsp_valid appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int          c_W     = 2;
    localparam int          c_DEPTH = 256;
    localparam logic [31:0] c_IO    = 32'h0000_1000;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        req_valid    = 1'b0;
    logic        req_we       = 1'b0;
    logic [1:0]  req_size     = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr     = 32'h0;
    logic [31:0] req_wdata    = 32'h0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] io_out;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH       (c_DEPTH),
        .WAIT_CYCLES (c_W),
        .IO_BASE     (c_IO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .io_out       (io_out)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic        chk_data;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rdata;
    logic [31:0] v1, v2, v3;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One request from the IDLE cycle to the cycle after the response strobe.
    // Control returns 1 ns after a rising edge, with the DUT back in IDLE.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic e_err, input logic [31:0] e_data,
                          input logic chk_data, input string tag);
        int   n;
        int   lat;
        logic busy_low;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) begin
            chk(32'(req_ready), 32'd1, {tag, " ready timeout"});
            return;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        sb_q.push_back('{e_err, e_data, chk_data});
        @(posedge clk); #1;
        // Scramble the fields after accept; the DUT must use its latched copy.
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat      = 1;
        busy_low = 1'b1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (req_ready !== 1'b0) busy_low = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (rsp_valid !== 1'b1) begin
            chk(32'(rsp_valid), 32'd1, {tag, " response timeout"});
            void'(sb_q.pop_front());
            return;
        end
        if (req_ready !== 1'b0) busy_low = 1'b0;
        e = sb_q.pop_front();
        chk(32'(lat), e.err ? 32'd1 : 32'(c_W + 1), {tag, " latency"});
        chk(32'(rsp_err), 32'(e.err), {tag, " err"});
        if (e.chk_data) chk(rsp_rdata, e.data, {tag, " rdata"});
        chk(32'(busy_low), 32'd1, {tag, " ready low while busy"});
        last_rdata = rsp_rdata;
        @(posedge clk); #1;
        chk(32'(rsp_valid), 32'd0, {tag, " strobe one cycle"});
        if (e.chk_data) chk(rsp_rdata, e.data, {tag, " rdata hold"});
    endtask

    task automatic chk_all_zero(input string tag);
        chk(32'(req_ready), 32'd0, {tag, " req_ready"});
        chk(32'(rsp_valid), 32'd0, {tag, " rsp_valid"});
        chk(32'(rsp_err),   32'd0, {tag, " rsp_err"});
        chk(rsp_rdata,      32'd0, {tag, " rsp_rdata"});
        chk(io_out,         32'd0, {tag, " io_out"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Word store latency and ready behaviour
        do_req(1'b1, SZ_W, 1'b0, 32'h8,  32'h1234_5678, 1'b0, 32'h0, 1'b1, "st_w_8");
        do_req(1'b1, SZ_W, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1, "st_w_10");

        // Sub-word loads and stores with extension
        do_req(1'b0, SZ_B, 1'b0, 32'hB, 32'h0,         1'b0, 32'h0000_0012, 1'b1, "ld_b_B_s");
        do_req(1'b1, SZ_B, 1'b0, 32'h9, 32'h5A5A_5A80, 1'b0, 32'h0,         1'b1, "st_b_9");
        do_req(1'b0, SZ_B, 1'b0, 32'h9, 32'h0,         1'b0, 32'hFFFF_FF80, 1'b1, "ld_b_9_s");
        do_req(1'b0, SZ_B, 1'b1, 32'h9, 32'h0,         1'b0, 32'h0000_0080, 1'b1, "ld_b_9_u");
        do_req(1'b0, SZ_H, 1'b0, 32'hA, 32'h0,         1'b0, 32'h0000_1234, 1'b1, "ld_h_A");
        do_req(1'b0, SZ_H, 1'b0, 32'h8, 32'h0,         1'b0, 32'hFFFF_8078, 1'b1, "ld_h_8_s");
        do_req(1'b0, SZ_H, 1'b1, 32'h8, 32'h0,         1'b0, 32'h0000_8078, 1'b1, "ld_h_8_u");
        do_req(1'b0, SZ_W, 1'b1, 32'h8, 32'h0,         1'b0, 32'h1234_8078, 1'b1, "ld_w_8");
        do_req(1'b1, SZ_H, 1'b0, 32'hE, 32'h0000_BEEF, 1'b0, 32'h0,         1'b1, "st_h_E");
        do_req(1'b0, SZ_W, 1'b0, 32'hC, 32'h0,         1'b0, 32'hBEEF_0000 | 32'h0, 1'b0, "ld_w_C");
        do_req(1'b0, SZ_H, 1'b0, 32'hE, 32'h0,         1'b0, 32'hFFFF_BEEF, 1'b1, "ld_h_E_s");

        // Error cases: no side effects
        do_req(1'b0, SZ_H, 1'b0, 32'h3,   32'h0,         1'b1, 32'h0, 1'b1, "err_ld_h_3");
        do_req(1'b0, SZ_W, 1'b0, 32'h6,   32'h0,         1'b1, 32'h0, 1'b1, "err_ld_w_6");
        do_req(1'b0, 2'd3, 1'b0, 32'h8,   32'h0,         1'b1, 32'h0, 1'b1, "err_size3");
        do_req(1'b0, SZ_W, 1'b0, 32'(4 * c_DEPTH), 32'h0, 1'b1, 32'h0, 1'b1, "err_ld_unmapped");
        do_req(1'b1, SZ_H, 1'b0, 32'h9,   32'h0000_FFFF, 1'b1, 32'h0, 1'b1, "err_st_h_9");
        do_req(1'b1, SZ_W, 1'b0, 32'(4 * c_DEPTH), 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, "err_st_unmapped");
        do_req(1'b0, SZ_W, 1'b0, 32'h8,   32'h0,         1'b0, 32'h1234_8078, 1'b1, "ld_w_8_after_err");

        // MMIO
        do_req(1'b1, SZ_W, 1'b0, c_IO, 32'h0000_00A5, 1'b0, 32'h0, 1'b1, "st_io_out");
        chk(io_out, 32'h0000_00A5, "io_out after store");
        do_req(1'b0, SZ_W, 1'b0, c_IO, 32'h0, 1'b0, 32'h0000_00A5, 1'b1, "ld_io_out");
        do_req(1'b1, SZ_B, 1'b0, c_IO, 32'h0000_0077, 1'b1, 32'h0, 1'b1, "err_st_b_io");
        chk(io_out, 32'h0000_00A5, "io_out after byte store");
        do_req(1'b1, SZ_W, 1'b0, c_IO + 32'd4, 32'h1, 1'b1, 32'h0, 1'b1, "err_st_cyc");
        do_req(1'b0, SZ_H, 1'b0, c_IO, 32'h0, 1'b1, 32'h0, 1'b1, "err_ld_h_io");
        do_req(1'b0, SZ_W, 1'b0, c_IO + 32'd8, 32'h0, 1'b1, 32'h0, 1'b1, "err_ld_io_gap");

        // Cycle counter spacing and wrap
        do_req(1'b0, SZ_W, 1'b0, c_IO + 32'd4, 32'h0, 1'b0, 32'h0, 1'b0, "ld_cyc_1");
        v1 = last_rdata;
        do_req(1'b0, SZ_W, 1'b0, c_IO + 32'd4, 32'h0, 1'b0, 32'h0, 1'b0, "ld_cyc_2");
        v2 = last_rdata;
        chk(v2 - v1, 32'(c_W + 2), "cyc delta k=0");
        repeat (3) @(posedge clk);
        #1;
        do_req(1'b0, SZ_W, 1'b0, c_IO + 32'd4, 32'h0, 1'b0, 32'h0, 1'b0, "ld_cyc_3");
        v3 = last_rdata;
        chk(v3 - v2, 32'(3 + c_W + 2), "cyc delta k=3");
        force dut.r_cyc_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_cyc_cnt;
        @(posedge clk); #1;
        chk(dut.r_cyc_cnt, 32'h0, "cyc wrap");
        do_req(1'b0, SZ_W, 1'b0, c_IO + 32'd4, 32'h0, 1'b0, 32'(c_W), 1'b1, "ld_cyc_after_wrap");

        // Reset in the middle of a store's wait phase
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_W;
        req_addr  = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk(32'(req_ready), 32'd0, "mid-wait busy");
        reset = 1'b1;
        #1 chk_all_zero("reset mid-wait");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        do_req(1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, "ld_w_10_after_reset");
        chk(io_out, 32'h0, "io_out after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
